// File: rtl/div_16by8_seq_pkg.sv
// Shared arithmetic definitions for the 16-by-8 sequential divider:
// FSM state encoding, operand widths, counter width and the fixed
// results reported for a zero divisor.
package div_16by8_seq_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  // Wide enough to hold the full iteration count of DIVIDEND_W.
  localparam int CNT_W      = 5;

  localparam logic [DIVIDEND_W-1:0] DZ_QUOT = 16'hFFFF;
  localparam logic                  DZ_FLAG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_16by8_seq_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and conditionally subtract the divisor.
// Ports:
//   rem      in  8  partial remainder, always < b
//   dbit     in  1  next dividend bit (MSB first)
//   b        in  8  divisor (non-zero)
//   rem_next out 8  updated partial remainder
//   qbit     out 1  quotient bit produced by this step
module div_step
  import div_16by8_seq_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic                 dbit,
  input  logic [DIVISOR_W-1:0] b,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic                 qbit
);

  // Because rem < b, the shifted value {rem,dbit} is at most 2b-1, so the
  // trial difference lies in -255..254 and a 9-bit signed result is exact.
  logic signed [DIVISOR_W:0] trial;

  assign trial    = $signed({rem, dbit}) - $signed({1'b0, b});
  assign qbit     = ~trial[DIVISOR_W];
  // On a failed trial the shifted value is < b, so its top bit is zero.
  assign rem_next = qbit ? trial[DIVISOR_W-1:0] : {rem[DIVISOR_W-2:0], dbit};

endmodule

// File: rtl/div_16by8_seq.sv
// Sequential 16-by-8 restoring divider, one quotient bit per clock.
// TRUNC low quotient bits are skipped (approximate mode, 0..8).
// Ports:
//   clk   in   1   clock, rising edge
//   rst   in   1   synchronous active-high reset
//   start in   1   request, sampled in IDLE or DONE
//   A     in  16   dividend, captured on the accepting edge
//   B     in   8   divisor, captured on the accepting edge
//   busy  out  1   high while dividing
//   done  out  1   one-cycle pulse; Q, R, dz valid while high
//   Q     out 16   quotient
//   R     out  8   remainder
//   dz    out  1   divide-by-zero flag
module div_16by8_seq
  import div_16by8_seq_pkg::*;
#(
  parameter int TRUNC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  dz
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - TRUNC);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   q_q, q_d;
  logic [DIVISOR_W-1:0]    r_q, r_d;
  logic                    dz_q, dz_d;

  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVIDEND_W-2:0]   quo_q, quo_d;
  logic [DIVISOR_W-1:0]    div_q, div_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;

  logic [DIVISOR_W-1:0]    step_rem;
  logic                    step_qbit;

  div_step u_step (
    .rem      (rem_q),
    .dbit     (dvd_q[DIVIDEND_W-1]),
    .b        (div_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    div_d   = div_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (B == '0) begin
            state_d = DONE;
            q_d     = DZ_QUOT;
            r_d     = A[DIVISOR_W-1:0];
            dz_d    = DZ_FLAG;
          end else begin
            state_d = CALC;
            dvd_d   = A;
            div_d   = B;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = {quo_q[DIVIDEND_W-3:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          // Skipped low bits come back as zeros.
          q_d     = {quo_q, step_qbit} << TRUNC;
          r_d     = step_rem;
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath working registers
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    quo_q <= quo_d;
    div_q <= div_d;
    rem_q <= rem_d;
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_16by8_seq.sv
// Bench for div_16by8_seq: two instances (TRUNC=0 and TRUNC=4) with
// directed cases and randomized operation chains, compared against a
// plain-arithmetic model of quotient, remainder and latency.
module tb_div_16by8_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel4 = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  B = '0;

  logic        start0, start4;
  logic        busy0, done0, dz0, busy4, done4, dz4;
  logic [15:0] Q0, Q4;
  logic [7:0]  R0, R4;

  logic        o_busy, o_done, o_dz;
  logic [15:0] o_q;
  logic [7:0]  o_r;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] op_a [16];
  logic [7:0]  op_b [16];

  always #5 clk = ~clk;

  assign start0 = start & ~sel4;
  assign start4 = start & sel4;
  assign o_busy = sel4 ? busy4 : busy0;
  assign o_done = sel4 ? done4 : done0;
  assign o_q    = sel4 ? Q4 : Q0;
  assign o_r    = sel4 ? R4 : R0;
  assign o_dz   = sel4 ? dz4 : dz0;

  div_16by8_seq #(.TRUNC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .A(A), .B(B),
    .busy(busy0), .done(done0), .Q(Q0), .R(R0), .dz(dz0)
  );

  div_16by8_seq #(.TRUNC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A), .B(B),
    .busy(busy4), .done(done4), .Q(Q4), .R(R4), .dz(dz4)
  );

  // Reference: quotient/remainder from integer division; latency counted
  // in edges after the accepting edge.
  task automatic model(input int t, input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] eq, output logic [7:0] er,
                       output logic edz, output int lat);
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = a[7:0]; edz = 1'b1; lat = 0;
    end else begin
      eq  = 16'(((int'(a) / int'(b)) >> t) << t);
      er  = 8'((int'(a) >> t) % int'(b));
      edz = 1'b0;
      lat = 16 - t;
    end
  endtask

  // Runs op_a/op_b[0..n-1] back to back, start held in DONE between ops.
  task automatic run_ops(input int t, input int n);
    logic [15:0] eq; logic [7:0] er; logic edz;
    int lat, cyc, bcnt; bit got;
    sel4 = (t == 4);
    @(negedge clk);
    A = op_a[0]; B = op_b[0]; start = 1'b1;
    for (int i = 0; i < n; i++) begin
      model(t, op_a[i], op_b[i], eq, er, edz, lat);
      @(posedge clk); #1;
      start = 1'b0; A = 16'($urandom); B = 8'($urandom);
      cyc = 0; bcnt = 0; got = 0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        if (o_done) got = 1;
        else begin
          if (o_busy) bcnt++;
          cyc++;
        end
      end
      vectors++;
      if (!got || cyc != lat) begin
        errors++;
        $display("FAIL latency t=%0d %0d/%0d: got %0d edges (done=%0d), expected %0d",
                 t, op_a[i], op_b[i], cyc, got, lat);
      end
      vectors++;
      if (bcnt != lat) begin
        errors++;
        $display("FAIL busy_cycles t=%0d %0d/%0d: got %0d, expected %0d",
                 t, op_a[i], op_b[i], bcnt, lat);
      end
      vectors++;
      if (o_q !== eq || o_r !== er || o_dz !== edz) begin
        errors++;
        $display("FAIL result t=%0d %0d/%0d: Q=%0d R=%0d dz=%b, expected Q=%0d R=%0d dz=%b",
                 t, op_a[i], op_b[i], o_q, o_r, o_dz, eq, er, edz);
      end
      if (i < n - 1) begin
        A = op_a[i+1]; B = op_b[i+1]; start = 1'b1;
      end
    end
    @(negedge clk);
    vectors++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse t=%0d: done=%b busy=%b, expected 0 0", t, o_done, o_busy);
    end
    vectors++;
    if (o_q !== eq || o_r !== er || o_dz !== edz) begin
      errors++;
      $display("FAIL result_hold t=%0d: Q=%0d R=%0d dz=%b, expected Q=%0d R=%0d dz=%b",
               t, o_q, o_r, o_dz, eq, er, edz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy0, done0, Q0, R0, dz0} !== 27'd0) begin
      errors++;
      $display("FAIL reset_t0: busy=%b done=%b Q=%0d R=%0d dz=%b, expected all 0",
               busy0, done0, Q0, R0, dz0);
    end
    vectors++;
    if ({busy4, done4, Q4, R4, dz4} !== 27'd0) begin
      errors++;
      $display("FAIL reset_t4: busy=%b done=%b Q=%0d R=%0d dz=%b, expected all 0",
               busy4, done4, Q4, R4, dz4);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    op_a[0] = 16'd1000;  op_b[0] = 8'd7;
    run_ops(0, 1);
    op_a[0] = 16'h1234;  op_b[0] = 8'd0;
    run_ops(0, 1);
    op_a[0] = 16'd0;     op_b[0] = 8'd255;
    op_a[1] = 16'd254;   op_b[1] = 8'd255;
    run_ops(0, 2);
  endtask

  task automatic test_back_to_back();
    op_a[0] = 16'hFFFF;  op_b[0] = 8'd1;
    op_a[1] = 16'd255;   op_b[1] = 8'd255;
    op_a[2] = 16'hABCD;  op_b[2] = 8'd0;
    op_a[3] = 16'hFFFF;  op_b[3] = 8'd255;
    run_ops(0, 4);
  endtask

  task automatic test_truncated();
    op_a[0] = 16'd1000;  op_b[0] = 8'd7;
    op_a[1] = 16'hFFFF;  op_b[1] = 8'd1;
    op_a[2] = 16'h00FF;  op_b[2] = 8'd0;
    op_a[3] = 16'd15;    op_b[3] = 8'd3;
    run_ops(4, 4);
  endtask

  task automatic test_start_ignored();
    int cyc; bit got;
    sel4 = 1'b0;
    @(negedge clk);
    A = 16'd1000; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (o_done) got = 1;
      else begin
        cyc++;
        if (cyc == 5) begin A = 16'd50; B = 8'd3; start = 1'b1; end
        else begin start = 1'b0; A = 16'($urandom); B = 8'($urandom); end
      end
    end
    start = 1'b0;
    vectors++;
    if (!got || cyc != 16) begin
      errors++;
      $display("FAIL ignored_latency: got %0d edges (done=%0d), expected 16", cyc, got);
    end
    vectors++;
    if (o_q !== 16'd142 || o_r !== 8'd6 || o_dz !== 1'b0) begin
      errors++;
      $display("FAIL ignored_result: Q=%0d R=%0d dz=%b, expected Q=142 R=6 dz=0",
               o_q, o_r, o_dz);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    bit seen;
    sel4 = 1'b0;
    @(negedge clk);
    A = 16'd1000; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 16'd50; B = 8'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    vectors++;
    if ({o_busy, o_done, o_q, o_r, o_dz} !== 27'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b done=%b Q=%0d R=%0d dz=%b, expected all 0",
               o_busy, o_done, o_q, o_r, o_dz);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_done || o_busy) seen = 1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL rst_abort: done/busy seen after abort, expected none");
    end
    op_a[0] = 16'd100; op_b[0] = 8'd9;
    run_ops(0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 5; i++) begin
        op_a[i] = 16'($urandom);
        op_b[i] = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      run_ops((k % 2 == 0) ? 0 : 4, 5);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_truncated();
    test_start_ignored();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_16by8_seq.md
DIV_16BY8_SEQ -- requirements
Module: div_16by8_seq

Interface
REQ-001 Parameter TRUNC, default 0, meaning: number of low quotient bits not computed (approximate mode); legal range 0..8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 A  input  16  dividend; captured on the accepting edge.
REQ-006 B  input  8  divisor; captured on the accepting edge.
REQ-007 busy  output  1  high while state is CALC.
REQ-008 done  output  1  one-cycle pulse; Q, R and dz are valid while it is high.
REQ-009 Q  output  16  quotient.
REQ-010 R  output  8  remainder.
REQ-011 dz  output  1  divide-by-zero flag for the current result.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 start=1 in IDLE or DONE with B!=0 SHALL load the operands, clear the partial remainder, set the iteration counter to 16-TRUNC and enter CALC.
REQ-014 start=1 in IDLE or DONE with B==0 SHALL enter DONE on the next edge with Q=16'hFFFF, R=A[7:0] and dz=1.
REQ-015 start while in CALC SHALL be ignored, with no effect on the operation in progress.
REQ-016 Each CALC cycle SHALL perform one restoring step, MSB first (9-bit trial remainder {rem,next dividend bit} minus B; if non-negative, keep the difference and set the quotient bit to 1, else keep the remainder and set the bit to 0), then decrement the counter.
REQ-017 After the step with counter==1, the FSM SHALL enter DONE; done SHALL therefore rise exactly 16-TRUNC edges after the accepting edge.
REQ-018 Results SHALL be Q = (floor(A/B) >> TRUNC) << TRUNC and R = floor(A/2^TRUNC) mod B; with TRUNC=0 this is exact division.
REQ-019 Q, R and dz SHALL be registered, updated only on entry to DONE, and held unchanged until the next DONE entry.
REQ-020 In DONE, done=1 and busy=0; the next state SHALL be CALC (or DONE for the B==0 case) if start=1, else IDLE, allowing back-to-back operations with no gap.
REQ-021 Operand inputs SHALL be don't-care except on the accepting edge.
REQ-022 The quotient SHALL never exceed 16 bits and the remainder SHALL never exceed B-1; no overflow flag exists.

Reset
REQ-023 rst=1 at a rising edge SHALL force state IDLE and busy=0, done=0, Q=0, R=0, dz=0, counter=0, regardless of state.
REQ-024 rst asserted mid-CALC SHALL abort the operation with no done pulse; rst SHALL take priority over a simultaneous start.

Structure
REQ-025 A shared arithmetic package SHALL hold the state enum (IDLE/CALC/DONE), DIVIDEND_W=16, DIVISOR_W=8 and the zero-divisor constants (Q=16'hFFFF).
REQ-026 One combinational sub-module, div_step, SHALL implement a single conditional subtract-shift (inputs: rem[7:0], bit, B; outputs: rem_next[7:0], qbit).
REQ-027 Estimated implementation size: 120-400 lines of RTL in total.

Verification
REQ-028 TRUNC=0, A=1000, B=7 -> done exactly 16 edges after start; Q=142, R=6, dz=0; busy high for 16 cycles.
REQ-029 TRUNC=0, A=16'hFFFF, B=1 -> Q=16'hFFFF, R=0; then A=255, B=255 back-to-back (start held in DONE) -> Q=1, R=0 with no IDLE gap.
REQ-030 A=16'h1234, B=0 -> done 1 edge after start; Q=16'hFFFF, R=8'h34, dz=1.
REQ-031 TRUNC=4, A=1000, B=7 -> done 12 edges after start; Q=128, R=6.
REQ-032 start pulsed with A=50, B=3 mid-CALC of a 1000/7 operation -> ignored; result Q=142, R=6.
REQ-033 rst at CALC cycle 5 -> IDLE next edge, all outputs 0, no done pulse; a subsequent 100/9 -> Q=11, R=1.
